// File: rtl/poly_seq_engine.sv
// poly_seq_engine: multi-voice square-wave song sequencer.
// A song of 2^STEP_W steps is walked at the sequencer tick rate; each step
// plays NUM_CH square voices whose half-periods come from an external LUT.
// The voices are mixed into a 1-bit first-order delta-sigma stream.
// Everything runs on clk with clock-enable ticks; there are no derived clocks.
module poly_seq_engine #(
  parameter int NUM_CH     = 2,
  parameter int HP_W       = 7,
  parameter int SYNTH_DIV  = 10,
  parameter int SEQ_DIV    = 17,
  parameter int STEP_TICKS = 20,
  parameter int GATE_TICKS = 10,
  parameter int STEP_W     = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   loop_en,
  input  logic [NUM_CH*HP_W-1:0] hp_in,
  output logic [STEP_W-1:0]      step_idx,
  output logic                   step_strobe,
  output logic                   gate,
  output logic                   done,
  output logic                   audio
);

  localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int ACC_W  = $clog2(NUM_CH) + 1;
  // One spare bit so acc + popcount never wraps before the threshold compare.
  localparam int MIX_W  = ACC_W + 1;

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(STEP_TICKS - 1);
  localparam logic [TICK_W:0]   GATE_LIM  = (TICK_W + 1)'(GATE_TICKS);
  localparam logic [MIX_W-1:0]  MIX_FULL  = MIX_W'(NUM_CH);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [SEQ_DIV-1:0]  pre_reg;
  logic [TICK_W-1:0]   tick_ctr_reg;
  logic [STEP_W-1:0]   step_idx_reg;
  logic                strobe_reg;
  logic                gate_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic                audio_reg;
  logic [NUM_CH-1:0]   voice_v;
  logic [MIX_W-1:0]    vsum;
  logic [MIX_W-1:0]    mix_total;

  // Time only advances while playing with run high. The PAUSE cycle in which
  // run returns already counts, so a pause of N low cycles delays the song by
  // exactly N clocks.
  logic counting;
  logic freeze;
  logic synth_tick;
  logic seq_tick;
  logic last_tick;
  logic last_step;
  logic song_end;
  logic in_window;
  logic voice_gate;

  assign counting   = run && (state_reg == PLAY || state_reg == PAUSE);
  assign freeze     = !run && (state_reg == PLAY || state_reg == PAUSE);
  assign synth_tick = counting && (&pre_reg[SYNTH_DIV-1:0]);
  assign seq_tick   = counting && (&pre_reg);
  assign last_tick  = (tick_ctr_reg == LAST_TICK);
  assign last_step  = &step_idx_reg;
  assign song_end   = seq_tick && last_tick && last_step && !loop_en;
  assign in_window  = ({1'b0, tick_ctr_reg} < GATE_LIM);
  // Voices run off the live tick counter; the gate output is its registered copy.
  assign voice_gate = (state_reg == PLAY || state_reg == PAUSE) && in_window;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: run/stop, pause/resume and end-of-song handling.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (run) state_next = PLAY;
      end
      PLAY, PAUSE: begin
        if (!run)          state_next = PAUSE;
        else if (song_end) state_next = DONE;
        else               state_next = PLAY;
      end
      DONE: begin
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler, per-step tick counter and song position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg      <= '0;
      tick_ctr_reg <= '0;
      step_idx_reg <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (run) begin
          pre_reg      <= '0;
          tick_ctr_reg <= '0;
          step_idx_reg <= '0;
        end
      end else if (counting) begin
        pre_reg <= pre_reg + SEQ_DIV'(1);
        if (seq_tick) begin
          if (last_tick) begin
            tick_ctr_reg <= '0;
            if (!last_step) begin
              step_idx_reg <= step_idx_reg + STEP_W'(1);
              strobe_reg   <= 1'b1;
            end else if (loop_en) begin
              step_idx_reg <= '0;
              strobe_reg   <= 1'b1;
            end
          end else begin
            tick_ctr_reg <= tick_ctr_reg + TICK_W'(1);
          end
        end
      end
    end
  end

  // Gate output: high only while the next state is PLAY inside the gate window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_reg <= 1'b0;
    end else begin
      gate_reg <= (state_next == PLAY) && in_window;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_voice
      logic [HP_W-1:0] hp_c;
      logic [HP_W-1:0] ph_reg;
      logic            v_reg;

      assign hp_c        = hp_in[gi*HP_W +: HP_W];
      assign voice_v[gi] = v_reg;

      // Square voice: hold while paused, silence outside the gate or on a rest,
      // otherwise toggle every hp_c synth ticks (>= so a shrinking hp_c never wraps).
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ph_reg <= '0;
          v_reg  <= 1'b0;
        end else if (freeze) begin
          ph_reg <= ph_reg;
          v_reg  <= v_reg;
        end else if (!voice_gate || hp_c == '0) begin
          ph_reg <= '0;
          v_reg  <= 1'b0;
        end else if (synth_tick) begin
          if (ph_reg >= hp_c - HP_W'(1)) begin
            ph_reg <= '0;
            v_reg  <= ~v_reg;
          end else begin
            ph_reg <= ph_reg + HP_W'(1);
          end
        end
      end
    end
  endgenerate

  // Count sounding voices; voices held during a pause are muted by the gate.
  always_comb begin
    vsum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      vsum = vsum + MIX_W'(voice_v[c] & gate_reg);
    end
  end

  assign mix_total = {1'b0, acc_reg} + vsum;

  // First-order delta-sigma: emit 1 whenever the accumulator reaches NUM_CH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg   <= '0;
      audio_reg <= 1'b0;
    end else if (mix_total >= MIX_FULL) begin
      acc_reg   <= ACC_W'(mix_total - MIX_FULL);
      audio_reg <= 1'b1;
    end else begin
      acc_reg   <= ACC_W'(mix_total);
      audio_reg <= 1'b0;
    end
  end

  assign step_idx    = step_idx_reg;
  assign step_strobe = strobe_reg;
  assign gate        = gate_reg;
  assign done        = (state_reg == DONE);
  assign audio       = audio_reg;

endmodule
